// File: rtl/fifo_rd_packer_pkg.sv
// fifo_rd_packer_pkg: defaults shared with the async FIFO and packer state encodings.
// Lane order convention: lane 0 (bits [DSIZE-1:0]) holds the oldest popped entry.
package fifo_rd_packer_pkg;
   localparam int DEF_DSIZE  = 8;
   localparam int DEF_ASIZE  = 3;
   localparam int DEF_NBEATS = 4;
   localparam int DEF_CW     = 3;
   localparam logic [0:0] S_FILL  = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;
endpackage

// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: FIFO read port, flush request and packed valid/ready output.
interface fifo_rd_packer_if #(
   parameter int DSIZE  = 8,
   parameter int NBEATS = 4,
   parameter int CW     = 3
);
   logic [DSIZE-1:0]        rdata;
   logic                    rempty;
   logic                    rinc;
   logic                    flush;
   logic [DSIZE*NBEATS-1:0] out_data;
   logic [CW-1:0]           out_cnt;
   logic                    out_valid;
   logic                    out_ready;
   modport master (output rdata, rempty, flush, out_ready, input rinc, out_data, out_cnt, out_valid);
   modport slave  (input rdata, rempty, flush, out_ready, output rinc, out_data, out_cnt, out_valid);
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops NBEATS FIFO entries per wide word, with flush of partial words.
module fifo_rd_packer
   import fifo_rd_packer_pkg::*;
#(
   parameter int DSIZE  = DEF_DSIZE,
   parameter int NBEATS = DEF_NBEATS,
   parameter int CW     = DEF_CW
) (
   input logic              rclk,
   input logic              rst,
   fifo_rd_packer_if.slave  bus
);
   localparam int W = DSIZE * NBEATS;
   localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);
   logic [0:0]    state;
   logic          flush_pend;
   logic [CW-1:0] cnt;
   logic [W-1:0]  acc;
   logic [W-1:0]  acc_w;
   logic [W-1:0]  data_q;
   logic [CW-1:0] cnt_q;
   logic          valid_q;
   logic          slot_free;
   logic          pop;
   assign slot_free = !valid_q || bus.out_ready;
   // the last lane may only be popped when the output register can take the word
   assign pop = !rst && state == S_FILL && !bus.rempty && !flush_pend && (cnt < LAST || slot_free);
   assign bus.rinc      = pop;
   assign bus.out_data  = data_q;
   assign bus.out_cnt   = cnt_q;
   assign bus.out_valid = valid_q;
   always_comb begin
      acc_w = acc;
      for (int i = 0; i < NBEATS; i++)
         if (cnt == CW'(i)) acc_w[i*DSIZE +: DSIZE] = bus.rdata;
   end
   always_ff @(posedge rclk) begin
      if (rst) begin
         state      <= S_FILL;
         flush_pend <= 1'b0;
         cnt        <= '0;
         acc        <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         if (bus.out_ready) valid_q <= 1'b0;
         if (state == S_FILL) begin
            if (bus.flush) begin
               flush_pend <= 1'b1;
               state      <= S_FLUSH;
            end
            if (pop) begin
               if (cnt == LAST) begin
                  data_q  <= acc_w;
                  cnt_q   <= CW'(NBEATS);
                  valid_q <= 1'b1;
                  cnt     <= '0;
                  acc     <= '0;
               end else begin
                  acc <= acc_w;
                  cnt <= cnt + 1'b1;
               end
            end
         end else if (cnt == '0) begin
            flush_pend <= 1'b0;
            state      <= S_FILL;
         end else if (slot_free) begin
            // acc upper lanes are already zero since it is cleared on every emission
            data_q     <= acc;
            cnt_q      <= cnt;
            valid_q    <= 1'b1;
            cnt        <= '0;
            acc        <= '0;
            flush_pend <= 1'b0;
            state      <= S_FILL;
         end
      end
   end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: packer fed by a show-ahead behavioural FIFO sharing its clock.
module tb_fifo_rd_packer;
   import fifo_rd_packer_pkg::*;
   localparam int DEPTH = 1 << DEF_ASIZE;
   typedef struct {
      logic [7:0]  d [4];
      logic [31:0] exp;
   } vec_t;
   logic rclk = 1'b0;
   logic rst = 1'b1;
   logic fifo_rst = 1'b1;
   logic wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic [7:0] mem [DEPTH];
   logic [DEF_ASIZE:0] wp, rp;
   int errors = 0;
   int checks = 0;
   fifo_rd_packer_if #(.DSIZE(8), .NBEATS(4), .CW(3)) bus ();
   fifo_rd_packer #(.DSIZE(8), .NBEATS(4), .CW(3)) dut (.rclk(rclk), .rst(rst), .bus(bus));
   always #5 rclk = ~rclk;
   always @(posedge rclk) begin
      if (fifo_rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_en) begin
            mem[wp[DEF_ASIZE-1:0]] <= wr_data;
            wp <= wp + 1'b1;
         end
         if (bus.rinc) rp <= rp + 1'b1;
      end
   end
   assign bus.rempty = (wp == rp);
   assign bus.rdata  = mem[rp[DEF_ASIZE-1:0]];
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic push(input logic [7:0] b);
      wr_en = 1'b1;
      wr_data = b;
      @(negedge rclk);
      wr_en = 1'b0;
   endtask
   task automatic wait_valid(input string nm);
      int i = 0;
      while (!bus.out_valid && i < 50) begin
         @(negedge rclk);
         i++;
      end
      chk({nm, " valid"}, 64'(bus.out_valid), 64'd1);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge rclk);
   endtask
   vec_t vecs [3];
   logic prev_rinc;
   logic saw;
   initial begin
      vecs[0].d = '{8'h10, 8'h20, 8'h30, 8'h40}; vecs[0].exp = 32'h40302010;
      vecs[1].d = '{8'hFF, 8'h00, 8'h80, 8'h7F}; vecs[1].exp = 32'h7F8000FF;
      vecs[2].d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; vecs[2].exp = 32'hEFBEADDE;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      idle(2);
      fifo_rst = 1'b0;
      // reset held while the FIFO fills
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      idle(3);
      chk("rst rinc", 64'(bus.rinc), 64'd0);
      chk("rst valid", 64'(bus.out_valid), 64'd0);
      chk("rst data", 64'(bus.out_data), 64'd0);
      chk("rst cnt", 64'(bus.out_cnt), 64'd0);
      chk("rst fifo kept", 64'(bus.rempty), 64'd0);
      bus.out_ready = 1'b1;
      rst = 1'b0;
      prev_rinc = 1'b0;
      for (int i = 0; i < 20 && !bus.out_valid; i++) begin
         @(negedge rclk);
         if (!bus.out_valid) prev_rinc = bus.rinc;
      end
      chk("w1 latency", 64'(prev_rinc), 64'd1);
      chk("w1 valid", 64'(bus.out_valid), 64'd1);
      chk("w1 data", 64'(bus.out_data), 64'h44332211);
      chk("w1 cnt", 64'(bus.out_cnt), 64'd4);
      @(negedge rclk);
      chk("w1 drop", 64'(bus.out_valid), 64'd0);
      for (int v = 0; v < 3; v++) begin
         for (int j = 0; j < 4; j++) push(vecs[v].d[j]);
         wait_valid($sformatf("vec%0d", v));
         chk($sformatf("vec%0d data", v), 64'(bus.out_data), 64'(vecs[v].exp));
         chk($sformatf("vec%0d cnt", v), 64'(bus.out_cnt), 64'd4);
         @(negedge rclk);
      end
      // backpressure: first word held, three more pops, then stall
      bus.out_ready = 1'b0;
      for (int j = 1; j <= 8; j++) push(8'(j));
      idle(5);
      for (int k = 0; k < 3; k++) begin
         chk("hold valid", 64'(bus.out_valid), 64'd1);
         chk("hold data", 64'(bus.out_data), 64'h04030201);
         @(negedge rclk);
      end
      chk("hold rinc", 64'(bus.rinc), 64'd0);
      chk("hold fifo", 64'(bus.rempty), 64'd0);
      bus.out_ready = 1'b1;
      @(negedge rclk);
      chk("b2b valid", 64'(bus.out_valid), 64'd1);
      chk("b2b data", 64'(bus.out_data), 64'h08070605);
      chk("b2b cnt", 64'(bus.out_cnt), 64'd4);
      @(negedge rclk);
      chk("b2b drop", 64'(bus.out_valid), 64'd0);
      // flush of a partial word after the FIFO drains
      push(8'hA1); push(8'hA2);
      idle(4);
      chk("fl empty", 64'(bus.rempty), 64'd1);
      chk("fl novalid", 64'(bus.out_valid), 64'd0);
      bus.flush = 1'b1;
      @(negedge rclk);
      bus.flush = 1'b0;
      wait_valid("fl");
      chk("fl data", 64'(bus.out_data), 64'h0000A2A1);
      chk("fl cnt", 64'(bus.out_cnt), 64'd2);
      @(negedge rclk);
      bus.flush = 1'b1;
      @(negedge rclk);
      bus.flush = 1'b0;
      saw = 1'b0;
      for (int k = 0; k < 6; k++) begin
         saw = saw | bus.out_valid;
         @(negedge rclk);
      end
      chk("fl0 none", 64'(saw), 64'd0);
      // flush coinciding with the second pop
      wr_en = 1'b1; wr_data = 8'hB1;
      @(negedge rclk);
      wr_data = 8'hB2;
      @(negedge rclk);
      chk("fl2 pop2", 64'(bus.rinc), 64'd1);
      wr_data = 8'hB3;
      bus.flush = 1'b1;
      @(negedge rclk);
      wr_en = 1'b0;
      bus.flush = 1'b0;
      chk("fl2 blocked", 64'(bus.rinc), 64'd0);
      wait_valid("fl2");
      chk("fl2 data", 64'(bus.out_data), 64'h0000B2B1);
      chk("fl2 cnt", 64'(bus.out_cnt), 64'd2);
      @(negedge rclk);
      push(8'hC1); push(8'hC2); push(8'hC3);
      wait_valid("b3");
      chk("b3 data", 64'(bus.out_data), 64'hC3C2C1B3);
      @(negedge rclk);
      // reset with a pending word and three packed lanes
      bus.out_ready = 1'b0;
      for (int j = 0; j < 8; j++) push(8'h61 + 8'(j));
      idle(5);
      chk("r6 pre valid", 64'(bus.out_valid), 64'd1);
      chk("r6 pre rinc", 64'(bus.rinc), 64'd0);
      rst = 1'b1;
      @(negedge rclk);
      chk("r6 valid", 64'(bus.out_valid), 64'd0);
      chk("r6 data", 64'(bus.out_data), 64'd0);
      chk("r6 cnt", 64'(bus.out_cnt), 64'd0);
      chk("r6 rinc", 64'(bus.rinc), 64'd0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      push(8'h71); push(8'h72); push(8'h73);
      wait_valid("r6 new");
      chk("r6 new data", 64'(bus.out_data), 64'h73727168);
      chk("r6 new cnt", 64'(bus.out_cnt), 64'd4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
